// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
// Shares one downstream AXI burst read port between two read requesters.
// AR requests are granted round-robin and forwarded through a registered AR
// stage. A 1-bit in-order grant FIFO records which requester owns each burst
// in flight, so R beats are routed back without an AXI ID.
//
// Ports
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   S0_AR* / S1_AR*          requester address channels (ARREADY combinational)
//   S0_R*  / S1_R*           requester read data channels (data broadcast,
//                            RVALID routed to the owning requester only)
//   M_AR*                    registered downstream address channel
//   M_R*                     downstream read data channel (M_RREADY combinational)
//   Outstanding              bursts granted whose RLAST has not yet returned
//   RespErr                  sticky flag: an accepted beat had RRESP != OKAY
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
   parameter int MAX_OUTST = 4
) (
   input  logic                           ACLK,
   input  logic                           ARESETn,
   input  logic [31:0]                    S0_ARADDR,
   input  logic [7:0]                     S0_ARLEN,
   input  logic [2:0]                     S0_ARSIZE,
   input  logic [1:0]                     S0_ARBURST,
   input  logic                           S0_ARVALID,
   output logic                           S0_ARREADY,
   output logic [31:0]                    S0_RDATA,
   output logic [1:0]                     S0_RRESP,
   output logic                           S0_RLAST,
   output logic                           S0_RVALID,
   input  logic                           S0_RREADY,
   input  logic [31:0]                    S1_ARADDR,
   input  logic [7:0]                     S1_ARLEN,
   input  logic [2:0]                     S1_ARSIZE,
   input  logic [1:0]                     S1_ARBURST,
   input  logic                           S1_ARVALID,
   output logic                           S1_ARREADY,
   output logic [31:0]                    S1_RDATA,
   output logic [1:0]                     S1_RRESP,
   output logic                           S1_RLAST,
   output logic                           S1_RVALID,
   input  logic                           S1_RREADY,
   output logic [31:0]                    M_ARADDR,
   output logic [7:0]                     M_ARLEN,
   output logic [2:0]                     M_ARSIZE,
   output logic [1:0]                     M_ARBURST,
   output logic                           M_ARVALID,
   input  logic                           M_ARREADY,
   input  logic [31:0]                    M_RDATA,
   input  logic [1:0]                     M_RRESP,
   input  logic                           M_RLAST,
   input  logic                           M_RVALID,
   output logic                           M_RREADY,
   output logic [$clog2(MAX_OUTST):0]     Outstanding,
   output logic                           RespErr
);

   localparam int AW = $clog2(MAX_OUTST);
   localparam int CW = AW + 1;

   // Two-bit encoding so that unused codes exist and are explicitly recovered.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_ar_load;
   logic                w_ar_clr;

   logic                r_last_gnt;      // 0 = S0 granted last, 1 = S1
   logic [31:0]         r_araddr;
   logic [7:0]          r_arlen;
   logic [2:0]          r_arsize;
   logic [1:0]          r_arburst;
   logic                r_arvalid;

   logic                r_fifo [MAX_OUTST];
   logic [AW-1:0]       r_wptr;
   logic [AW-1:0]       r_rptr;
   logic [CW-1:0]       r_count;
   logic                r_resp_err;

   logic                w_full;
   logic                w_empty;
   logic                w_win;           // 0 = S0 wins, 1 = S1 wins
   logic                w_grant;
   logic                w_head;
   logic                w_push;
   logic                w_pop;
   logic                w_beat;

   assign w_full  = (r_count == CW'(MAX_OUTST));
   assign w_empty = (r_count == {CW{1'b0}});

   // Contested requests go to whoever was not granted last; otherwise the sole requester wins.
   assign w_win   = (S0_ARVALID & S1_ARVALID) ? ~r_last_gnt : S1_ARVALID;

   // Grant is evaluated on the registered count, so a pop while full only frees a slot next cycle.
   assign w_grant = (r_state == ST_IDLE) & ~w_full & (S0_ARVALID | S1_ARVALID);
   assign w_push  = w_grant;

   assign S0_ARREADY = w_grant & ~w_win;
   assign S1_ARREADY = w_grant &  w_win;

   // R routing: zero-latency mux steered by the owner of the oldest burst.
   assign w_head    = r_fifo[r_rptr];
   assign S0_RDATA  = M_RDATA;
   assign S1_RDATA  = M_RDATA;
   assign S0_RRESP  = M_RRESP;
   assign S1_RRESP  = M_RRESP;
   assign S0_RLAST  = M_RLAST;
   assign S1_RLAST  = M_RLAST;
   assign S0_RVALID = M_RVALID & ~w_empty & ~w_head;
   assign S1_RVALID = M_RVALID & ~w_empty &  w_head;
   assign M_RREADY  = ~w_empty & (w_head ? S1_RREADY : S0_RREADY);
   assign w_beat    = M_RVALID & M_RREADY;
   assign w_pop     = w_beat & M_RLAST;

   assign M_ARADDR    = r_araddr;
   assign M_ARLEN     = r_arlen;
   assign M_ARSIZE    = r_arsize;
   assign M_ARBURST   = r_arburst;
   assign M_ARVALID   = r_arvalid;
   assign Outstanding = r_count;
   assign RespErr     = r_resp_err;

   // AR state register.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // AR next-state logic and load/clear strobes for the AR output stage.
   always_comb begin
      w_state_nxt = r_state;
      w_ar_load   = 1'b0;
      w_ar_clr    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant) begin
               w_state_nxt = ST_ISSUE;
               w_ar_load   = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (r_arvalid & M_ARREADY) begin
               w_state_nxt = ST_IDLE;
               w_ar_clr    = 1'b1;
            end else begin
               w_state_nxt = ST_ISSUE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_ar_clr    = 1'b1;
         end
      endcase
   end

   // Registered AR stage and round-robin pointer.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_araddr   <= 32'h0000_0000;
         r_arlen    <= 8'h00;
         r_arsize   <= 3'b000;
         r_arburst  <= 2'b00;
         r_arvalid  <= 1'b0;
         r_last_gnt <= 1'b1;
      end else if (w_ar_load) begin
         r_araddr   <= w_win ? S1_ARADDR  : S0_ARADDR;
         r_arlen    <= w_win ? S1_ARLEN   : S0_ARLEN;
         r_arsize   <= w_win ? S1_ARSIZE  : S0_ARSIZE;
         r_arburst  <= w_win ? S1_ARBURST : S0_ARBURST;
         r_arvalid  <= 1'b1;
         r_last_gnt <= w_win;
      end else if (w_ar_clr) begin
         r_arvalid  <= 1'b0;
      end else begin
         r_arvalid  <= r_arvalid;
      end
   end

   // Grant FIFO storage and pointers; the count doubles as Outstanding.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int i = 0; i < MAX_OUTST; i++) begin
            r_fifo[i] <= 1'b0;
         end
         r_wptr  <= {AW{1'b0}};
         r_rptr  <= {AW{1'b0}};
         r_count <= {CW{1'b0}};
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= w_win;
            r_wptr         <= r_wptr + {{(AW-1){1'b0}}, 1'b1};
         end
         if (w_pop) begin
            r_rptr <= r_rptr + {{(AW-1){1'b0}}, 1'b1};
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky error flag on any accepted non-OKAY beat.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_resp_err <= 1'b0;
      end else if (w_beat && (M_RRESP != 2'b00)) begin
         r_resp_err <= 1'b1;
      end else begin
         r_resp_err <= r_resp_err;
      end
   end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-to-one AXI read-channel arbiter that shares one burst read port into the HPS/SDRAM bridge between two read requesters: the frame-buffer read controller and a second DMA reader. AR requests are granted round-robin and forwarded through a registered AR stage. An in-order grant FIFO routes each R burst back to the requester that issued it, so no AXI ID is needed downstream. The block sits between the requesters' AXI read ports and the single downstream master port.

## Interface
- MAX_OUTST, 4, maximum bursts in flight downstream; power of two, 2..16
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- S0_ARADDR / S1_ARADDR  in  32  requester burst address
- S0_ARLEN / S1_ARLEN  in  8  requester burst length-1
- S0_ARSIZE / S1_ARSIZE  in  3  requester beat size
- S0_ARBURST / S1_ARBURST  in  2  requester burst type
- S0_ARVALID / S1_ARVALID  in  1  requester address valid
- S0_ARREADY / S1_ARREADY  out  1  address accepted from requester
- S0_RDATA / S1_RDATA  out  32  read data (M_RDATA broadcast)
- S0_RRESP / S1_RRESP  out  2  response (M_RRESP broadcast)
- S0_RLAST / S1_RLAST  out  1  last beat (M_RLAST broadcast)
- S0_RVALID / S1_RVALID  out  1  beat valid, routed to owning requester only
- S0_RREADY / S1_RREADY  in  1  requester beat ready
- M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST  out  32/8/3/2  registered downstream AR fields
- M_ARVALID  out  1  downstream address valid
- M_ARREADY  in  1  downstream address ready
- M_RDATA, M_RRESP, M_RLAST, M_RVALID  in  32/2/1/1  downstream read data channel
- M_RREADY  out  1  downstream beat ready
- Outstanding  out  $clog2(MAX_OUTST)+1  bursts granted but RLAST not yet received
- RespErr  out  1  sticky: any accepted beat had RRESP != 0

## Operation
- AR state machine, states IDLE and ISSUE.
- IDLE: if grant FIFO not full and any Sx_ARVALID, pick winner W. Both valid: W = requester not granted last (pointer LastGnt). One valid: W = that one.
- Sx_ARREADY = (state==IDLE) & (W==x) & ~full & Sx_ARVALID, combinational; never asserted for both requesters in the same cycle.
- On S_W handshake: latch the S_W AR fields into M_AR*, set M_ARVALID=1, push W into grant FIFO, set LastGnt=W, go to ISSUE.
- ISSUE: hold M_AR* stable. On M_ARVALID & M_ARREADY: M_ARVALID=0, go to IDLE. Maximum AR rate is one per 2 cycles.
- Grant FIFO: MAX_OUTST entries × 1 bit, head H valid when not empty.
- R routing, combinational:
  - Sx_RVALID = M_RVALID & ~empty & (H==x).
  - M_RREADY = ~empty & S_H_RREADY.
  - Empty FIFO: M_RREADY=0 and both Sx_RVALID=0; any stray beats are stalled, never dropped.
- Pop on M_RVALID & M_RREADY & M_RLAST.
- Outstanding equals FIFO count. A simultaneous push and pop leaves the count unchanged. Counter width must represent MAX_OUTST exactly.
- RespErr set on any M_RVALID & M_RREADY with M_RRESP != 0. Cleared only by reset.
- Unused state encodings return to IDLE with M_ARVALID=0.

## Timing
- Reset values:
  - M_ARVALID=0, M_ARADDR=0, M_ARLEN=0, M_ARSIZE=0, M_ARBURST=0.
  - State=IDLE, grant FIFO empty, Outstanding=0, RespErr=0.
  - LastGnt=1, so S0 wins the first contested arbitration.
  - All Sx_ARREADY/Sx_RVALID/M_RREADY are 0 because the FIFO is empty.
- AR latency: Sx handshake at edge N, M_ARVALID=1 with latched fields after edge N; earliest next Sx_ARREADY is the cycle after M_ARREADY is accepted.
- R path has zero-cycle latency: combinational through the routing mux, with no registers.
- Full FIFO (count==MAX_OUTST): no grant. A pop in the same cycle does not enable a grant that cycle; the grant occurs on the following cycle.
- Reset mid-burst: all state clears immediately; in-flight downstream beats are not routed after reset.

## Test plan
- Single S0 request ADDR=0x3000_0000, LEN=15, M_ARREADY tied 1 -> M_ARVALID one cycle with matching fields; 16 beats reach S0 only; Outstanding 1→0 after RLAST.
- S0 and S1 ARVALID held high continuously, M_ARREADY=1 -> grants alternate S0,S1,S0,S1; R bursts returned in order route to S0,S1,S0,S1.
- MAX_OUTST=4, R channel held off -> exactly 4 grants, Outstanding=4, both ARREADY stay 0; one RLAST → one more grant one cycle later.
- S1 RREADY=0 while its burst is at head -> M_RREADY=0, S0_RVALID=0; downstream stalls with no beat lost or misrouted.
- Beat with RRESP=2 -> RespErr=1 and stays set through later OKAY beats until ARESETn pulse.
- ARESETn asserted while in ISSUE with 3 outstanding -> M_ARVALID=0, Outstanding=0, S0 wins next contention.
